// File: rtl/instruction_executor.sv
// Multi-cycle executor: FETCH/DECODE/EXEC/WB sequencing with a 32-cycle
// shift-add multiplier and a 32x32 register file.
`timescale 1ns/1ps
module instruction_executor (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic        fetch_en,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic [15:0] retired,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);
    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MUL, WB
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_LI   = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    state_t      state_q, state_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] inst_q, inst_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [15:0] retired_q, retired_d;

    logic [2:0]  op;
    logic [31:0] imm;
    logic [31:0] acc_next;

    assign op  = inst_q[31:29];
    assign imm = {16'd0, inst_q[15:0]};

    always_comb begin
        state_d   = state_q;
        regs_d    = regs_q;
        inst_d    = inst_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        retired_d = retired_q;
        fetch_en  = 1'b0;
        acc_next  = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
        unique case (state_q)
            FETCH: begin
                fetch_en = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                inst_d  = instruction;
                op_a_d  = regs_q[instruction[28:24]];
                op_b_d  = regs_q[instruction[23:19]];
                state_d = EXEC;
            end
            EXEC: begin
                state_d   = WB;
                wb_addr_d = inst_q[18:14];
                unique case (op)
                    OP_NOP:  begin
                        state_d   = FETCH;
                        wb_addr_d = wb_addr_q;
                    end
                    OP_SUB:  wb_data_d = op_a_q - op_b_q;
                    OP_ADD:  wb_data_d = op_a_q + op_b_q;
                    OP_AND:  wb_data_d = op_a_q & op_b_q;
                    OP_OR:   wb_data_d = op_a_q | op_b_q;
                    OP_LI:   begin
                        wb_data_d = imm;
                        wb_addr_d = inst_q[23:19];
                    end
                    OP_ADDI: begin
                        wb_data_d = op_a_q + imm;
                        wb_addr_d = inst_q[23:19];
                    end
                    OP_MUL:  begin
                        // destination is published only on entry to WB
                        wb_addr_d = wb_addr_q;
                        mcand_d   = op_a_q;
                        mplier_d  = op_b_q;
                        acc_d     = 32'd0;
                        cnt_d     = 5'd0;
                        state_d   = MUL;
                    end
                endcase
            end
            MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    wb_data_d = acc_next;
                    wb_addr_d = inst_q[18:14];
                    state_d   = WB;
                end
            end
            WB: begin
                regs_d[wb_addr_q] = wb_data_q;
                retired_d         = retired_q + 16'd1;
                state_d           = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            regs_q    <= '{default: '0};
            inst_q    <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            regs_q    <= regs_d;
            inst_q    <= inst_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            retired_q <= retired_d;
        end
    end

    assign wb_en    = (state_q == WB);
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign busy     = (state_q != FETCH);
    assign retired  = retired_q;
    assign dbg_data = regs_q[dbg_addr];
endmodule

// File: tb/tb_instruction_executor.sv
// Directed bench for instruction_executor with a registered fetch-stage model.
`timescale 1ns/1ps
module tb_instruction_executor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction;
    logic        fetch_en;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic [15:0] retired;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wb_cnt = 0;
    int wb_base = 0;
    int pc;
    logic [31:0] prog [64];

    instruction_executor dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .fetch_en(fetch_en), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .busy(busy), .retired(retired),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // upstream fetch stage: registered word, valid the cycle after fetch_en
    always @(posedge clk) begin
        if (reset) begin
            instruction <= 32'd0;
            pc <= 0;
        end else if (fetch_en) begin
            instruction <= (pc < 64) ? prog[pc] : 32'd0;
            pc <= pc + 1;
        end
    end

    always @(negedge clk)
        if (!reset && wb_en) wb_cnt <= wb_cnt + 1;

    function automatic logic [31:0] r_ins(input logic [2:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 14'd0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [2:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, 3'd0, imm};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        wb_base = wb_cnt;
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        clear_prog();
        do_reset();
        checks++;
        if (fetch_en !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch fetch_en=%b busy=%b want 1 0", fetch_en, busy);
        end
        checks++;
        if (retired !== 16'd0 || wb_en !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_out retired=%0d wb_en=%b addr=%0d data=%h want 0",
                     retired, wb_en, wb_addr, wb_data);
        end
        peek(5'd5, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL reset_reg r5=%h want 0", v);
        end
    endtask

    task automatic test_alu_mul_nop();
        logic [31:0] v;
        clear_prog();
        prog[0] = i_ins(3'd6, 5'd0, 5'd10, 16'd10);
        prog[1] = i_ins(3'd6, 5'd0, 5'd15, 16'd15);
        prog[2] = r_ins(3'd2, 5'd10, 5'd15, 5'd25);
        prog[3] = i_ins(3'd7, 5'd25, 5'd20, 16'd5);
        prog[4] = i_ins(3'd6, 5'd0, 5'd5, 16'd2);
        prog[5] = r_ins(3'd4, 5'd25, 5'd5, 5'd30);
        do_reset();
        wait_to(11);
        checks++;
        if (wb_en !== 1'b1 || wb_addr !== 5'd25 || wb_data !== 32'd25) begin
            errors++;
            $display("FAIL add_wb wb_en=%b addr=%0d data=%0d want 1 25 25",
                     wb_en, wb_addr, wb_data);
        end
        peek(5'd25, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL dbg_old r25=%0d want 0 during WB", v);
        end
        wait_to(12);
        peek(5'd25, v);
        checks++;
        if (v !== 32'd25 || retired !== 16'd3 || wb_cnt - wb_base !== 3) begin
            errors++;
            $display("FAIL add_seq r25=%0d retired=%0d pulses=%0d want 25 3 3",
                     v, retired, wb_cnt - wb_base);
        end
        checks++;
        if (wb_en !== 1'b0 || wb_addr !== 5'd25 || wb_data !== 32'd25) begin
            errors++;
            $display("FAIL wb_hold wb_en=%b addr=%0d data=%0d want 0 25 25",
                     wb_en, wb_addr, wb_data);
        end
        wait_to(54);
        checks++;
        if (wb_en !== 1'b0 || busy !== 1'b1 || wb_addr !== 5'd5) begin
            errors++;
            $display("FAIL mul_busy wb_en=%b busy=%b addr=%0d want 0 1 5",
                     wb_en, busy, wb_addr);
        end
        wait_to(55);
        checks++;
        if (wb_en !== 1'b1 || wb_addr !== 5'd30 || wb_data !== 32'd50) begin
            errors++;
            $display("FAIL mul_wb wb_en=%b addr=%0d data=%0d want 1 30 50",
                     wb_en, wb_addr, wb_data);
        end
        for (int c = 56; c <= 64; c++) begin
            wait_to(c);
            checks++;
            if (fetch_en !== ((c - 56) % 3 == 0) || wb_en !== 1'b0) begin
                errors++;
                $display("FAIL nop_period cycle=%0d fetch_en=%b wb_en=%b",
                         c, fetch_en, wb_en);
            end
        end
        peek(5'd20, v);
        checks++;
        if (v !== 32'd30) begin
            errors++;
            $display("FAIL addi r20=%0d want 30", v);
        end
        peek(5'd5, v);
        checks++;
        if (v !== 32'd2) begin
            errors++;
            $display("FAIL li r5=%0d want 2", v);
        end
        peek(5'd30, v);
        checks++;
        if (v !== 32'd50 || retired !== 16'd6 || wb_cnt - wb_base !== 6) begin
            errors++;
            $display("FAIL mul_seq r30=%0d retired=%0d pulses=%0d want 50 6 6",
                     v, retired, wb_cnt - wb_base);
        end
    endtask

    task automatic test_wrap_logic();
        logic [31:0] v;
        clear_prog();
        prog[0] = i_ins(3'd6, 5'd0, 5'd1, 16'd1);
        prog[1] = r_ins(3'd1, 5'd0, 5'd1, 5'd2);
        prog[2] = r_ins(3'd4, 5'd2, 5'd2, 5'd3);
        prog[3] = i_ins(3'd6, 5'd0, 5'd4, 16'h00F0);
        prog[4] = r_ins(3'd3, 5'd2, 5'd4, 5'd5);
        prog[5] = r_ins(3'd5, 5'd1, 5'd4, 5'd6);
        do_reset();
        wait_to(56);
        peek(5'd2, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sub_wrap r2=%h want ffffffff", v);
        end
        peek(5'd3, v);
        checks++;
        if (v !== 32'h0000_0001) begin
            errors++;
            $display("FAIL mul_wrap r3=%h want 00000001", v);
        end
        peek(5'd5, v);
        checks++;
        if (v !== 32'h0000_00F0) begin
            errors++;
            $display("FAIL and r5=%h want 000000f0", v);
        end
        peek(5'd6, v);
        checks++;
        if (v !== 32'h0000_00F1 || retired !== 16'd6) begin
            errors++;
            $display("FAIL or r6=%h retired=%0d want 000000f1 6", v, retired);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        clear_prog();
        prog[0] = i_ins(3'd6, 5'd0, 5'd1, 16'd3);
        prog[1] = r_ins(3'd2, 5'd1, 5'd1, 5'd1);
        prog[2] = r_ins(3'd2, 5'd1, 5'd1, 5'd1);
        prog[3] = r_ins(3'd2, 5'd1, 5'd1, 5'd1);
        do_reset();
        wait_to(16);
        peek(5'd1, v);
        checks++;
        if (v !== 32'd24 || retired !== 16'd4) begin
            errors++;
            $display("FAIL back_to_back r1=%0d retired=%0d want 24 4", v, retired);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] v;
        clear_prog();
        prog[0] = i_ins(3'd6, 5'd0, 5'd7, 16'd3);
        prog[1] = r_ins(3'd4, 5'd7, 5'd7, 5'd8);
        do_reset();
        wait_to(26);
        reset = 1'b1;
        tick();
        checks++;
        if (fetch_en !== 1'b1 || busy !== 1'b0 || wb_en !== 1'b0 || retired !== 16'd0) begin
            errors++;
            $display("FAIL mid_mul_reset fetch_en=%b busy=%b wb_en=%b retired=%0d want 1 0 0 0",
                     fetch_en, busy, wb_en, retired);
        end
        peek(5'd8, v);
        checks++;
        if (v !== 32'd0 || wb_addr !== 5'd0) begin
            errors++;
            $display("FAIL mid_mul_dest r8=%0d wb_addr=%0d want 0 0", v, wb_addr);
        end
        peek(5'd7, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL mid_mul_regs r7=%0d want 0", v);
        end
        clear_prog();
        prog[0] = i_ins(3'd6, 5'd0, 5'd11, 16'd9);
        do_reset();
        wait_to(3);
        checks++;
        if (wb_en !== 1'b1 || wb_addr !== 5'd11) begin
            errors++;
            $display("FAIL wb_cycle wb_en=%b addr=%0d want 1 11", wb_en, wb_addr);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        peek(5'd11, v);
        checks++;
        if (v !== 32'd0 || retired !== 16'd0) begin
            errors++;
            $display("FAIL wb_reset r11=%0d retired=%0d want 0 0", v, retired);
        end
    endtask

    initial begin
        clear_prog();
        test_reset();
        test_alu_mul_nop();
        test_wrap_logic();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
